alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, operand/result width, legal range 2..32.
REQ-002 The block SHALL have parameter OP_WIDTH, default 4, opcode width, fixed at 4.
REQ-003 The block SHALL derive SHW = clog2(DATA_WIDTH), the shift-amount width.
REQ-004 CLK  input  1  sole clock, all state changes on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 START  input  1  request, sampled only in IDLE.
REQ-007 IN0  input  DATA_WIDTH  operand A, latched on accepted START.
REQ-008 IN1  input  DATA_WIDTH  operand B, latched on accepted START.
REQ-009 OP  input  OP_WIDTH  opcode, latched on accepted START.
REQ-010 BUSY  output  1  high while the block is in EXEC or DONE.
REQ-011 DONE  output  1  one-cycle pulse, result and flags valid.
REQ-012 OUT  output  DATA_WIDTH  registered result, held until next DONE.
REQ-013 ZF / CF / NF  output  1 each  registered zero, carry/borrow, negative flags.

Function
REQ-014 The block SHALL implement states IDLE, EXEC, DONE; IDLE->EXEC on START, EXEC->DONE when iteration count reaches 0, DONE->IDLE unconditionally.
REQ-015 Accepting START in IDLE SHALL latch IN0, IN1, OP and load iteration count k: 0 for single-cycle ops, IN1[SHW-1:0] for 1101/1110, DATA_WIDTH for 1111.
REQ-016 DONE SHALL assert exactly k+1 cycles after the accepting edge; OUT and flags SHALL update on the same edge that raises DONE.
REQ-017 Single-cycle opcodes: 0000 NOT A, 0001 XOR, 0010 OR, 0011 AND, 0100 A-B, 0101 A+B, 0110 A>>1, 0111 A<<1, 1000 A-1, 1001 A+1, 1010 pass A, 1011 pass B, 1100 XNOR.
REQ-018 Multi-cycle opcodes: 1101 A<<n, 1110 A>>n (logical, one bit per EXEC cycle, n=IN1[SHW-1:0]), 1111 A*B low DATA_WIDTH bits via shift-add, one partial product per EXEC cycle.
REQ-019 All arithmetic SHALL be modulo 2^DATA_WIDTH; OUT SHALL carry the low DATA_WIDTH bits only.
REQ-020 ZF SHALL equal (OUT==0) and NF SHALL equal OUT[DATA_WIDTH-1] for every opcode except 1010/1011.
REQ-021 CF SHALL be: carry-out for 0101/1001; borrow (A<B, resp. A==0) for 0100/1000; shifted-out bit for 0110/0111; last shifted-out bit for 1101/1110 (0 when n=0); 1 when high product half is non-zero for 1111; 0 for logic ops 0000-0011, 1100.
REQ-022 Opcodes 1010/1011 SHALL update OUT but hold ZF, CF, NF unchanged.
REQ-023 START while BUSY SHALL be ignored with no effect on the operation in progress or the latched operands.
REQ-024 Input changes on IN0/IN1/OP after acceptance SHALL NOT affect the result.
REQ-025 START asserted in the DONE cycle SHALL be ignored; a new request is accepted no earlier than the next IDLE cycle.
REQ-026 Shift with n >= 0 SHALL never overflow the counter; n is taken modulo DATA_WIDTH by width truncation.

Reset
REQ-027 RST SHALL force state IDLE, BUSY=0, DONE=0, OUT=0, ZF=0, CF=0, NF=0 on the next rising CLK edge.
REQ-028 RST during EXEC or DONE SHALL abort the operation without a DONE pulse and without updating OUT or flags beyond their reset values.
REQ-029 RST SHALL take priority over START in the same cycle.

Verification
REQ-030 DATA_WIDTH=8, OP=0101, A=8'hFF, B=8'h01, START one cycle -> DONE 1 cycle later, OUT=8'h00, ZF=1, CF=1, NF=0.
REQ-031 OP=0100, A=8'h03, B=8'h05 -> OUT=8'hFE, CF=1, NF=1, ZF=0; then OP=1011, B=8'h00 -> OUT=8'h00, ZF/CF/NF unchanged (0/1/1).
REQ-032 OP=1101, A=8'h81, B=8'h03 -> BUSY high, DONE 4 cycles after acceptance, OUT=8'h08, CF=0; OP=1101, B=8'h00 -> DONE after 1 cycle, OUT=A, CF=0.
REQ-033 OP=1111, A=8'h10, B=8'h11 -> DONE 9 cycles after acceptance, OUT=8'h10, CF=1; A=8'h0F, B=8'h03 -> OUT=8'h2D, CF=0.
REQ-034 Start MUL, pulse START with different operands mid-EXEC, then assert RST at EXEC cycle 5 -> second START ignored, no DONE, OUT=0, flags 0, IDLE next cycle, fresh START accepted normally.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shifts and
// a shift-add multiplier, with registered result and flags.
module alu_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] IN0,
    input  logic [DATA_WIDTH-1:0] IN1,
    input  logic [OP_WIDTH-1:0]   OP,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] OUT,
    output logic                  ZF,
    output logic                  CF,
    output logic                  NF
);

    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [3:0]      op_q;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   k;
    logic            sc;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  mc;
    logic [W-1:0]    res;
    logic            cf_n;
    logic            setf;
    logic [W:0]      sum;
    logic [W:0]      diff;
    logic            accept;

    assign accept = (state == S_IDLE) && START;
    assign BUSY   = (state != S_IDLE);
    assign DONE   = (state == S_DONE);

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (START) state_n = S_EXEC;
            S_EXEC: if (cnt == '0) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Iteration count: shift amount truncated to SHW bits, W for multiply
    always_comb begin
        k = '0;
        case (OP[3:0])
            4'b1101, 4'b1110: k = CW'(IN1[SHW-1:0]);
            4'b1111:          k = CW'(W);
            default:          k = '0;
        endcase
    end

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        res  = '0;
        cf_n = 1'b0;
        setf = 1'b1;
        case (op_q)
            4'b0000: res = ~a_q;
            4'b0001: res = a_q ^ b_q;
            4'b0010: res = a_q | b_q;
            4'b0011: res = a_q & b_q;
            4'b0100: begin res = diff[W-1:0]; cf_n = diff[W]; end
            4'b0101: begin res = sum[W-1:0]; cf_n = sum[W]; end
            4'b0110: begin res = a_q >> 1; cf_n = a_q[0]; end
            4'b0111: begin res = a_q << 1; cf_n = a_q[W-1]; end
            4'b1000: begin res = a_q - W'(1); cf_n = (a_q == '0); end
            4'b1001: begin res = a_q + W'(1); cf_n = &a_q; end
            4'b1010: begin res = a_q; setf = 1'b0; end
            4'b1011: begin res = b_q; setf = 1'b0; end
            4'b1100: res = ~(a_q ^ b_q);
            4'b1101, 4'b1110: begin res = a_q; cf_n = sc; end
            default: begin res = prod[W-1:0]; cf_n = |prod[2*W-1:W]; end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            cnt  <= '0;
            sc   <= 1'b0;
            prod <= '0;
            mc   <= '0;
            OUT  <= '0;
            ZF   <= 1'b0;
            CF   <= 1'b0;
            NF   <= 1'b0;
        end else if (accept) begin
            a_q  <= IN0;
            b_q  <= IN1;
            op_q <= OP[3:0];
            cnt  <= k;
            sc   <= 1'b0;
            prod <= '0;
            mc   <= {{W{1'b0}}, IN0};
        end else if (state == S_EXEC) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
                case (op_q)
                    4'b1101: begin a_q <= a_q << 1; sc <= a_q[W-1]; end
                    4'b1110: begin a_q <= a_q >> 1; sc <= a_q[0]; end
                    4'b1111: begin
                        if (b_q[0]) prod <= prod + mc;
                        mc  <= mc << 1;
                        b_q <= b_q >> 1;
                    end
                    default: ;
                endcase
            end else begin
                OUT <= res;
                if (setf) begin
                    ZF <= (res == '0);
                    CF <= cf_n;
                    NF <= res[W-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq: opcode table plus hand-written
// sequences for start-in-done, start-while-busy and abort by reset.
module tb_alu_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [7:0] IN0;
    logic [7:0] IN1;
    logic [3:0] OP;
    logic       BUSY;
    logic       DONE;
    logic [7:0] OUT;
    logic       ZF;
    logic       CF;
    logic       NF;

    int total = 0;
    int bad   = 0;

    alu_seq #(.DATA_WIDTH(8), .OP_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .IN0(IN0), .IN1(IN1), .OP(OP),
        .BUSY(BUSY), .DONE(DONE), .OUT(OUT),
        .ZF(ZF), .CF(CF), .NF(NF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic       z;
        logic       c;
        logic       n;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] op, logic [7:0] a, logic [7:0] b,
                                logic [7:0] o, logic z, logic c, logic n,
                                int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.out = o;
        v.z = z; v.c = c; v.n = n; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one op from a non-busy point, scramble inputs after acceptance,
    // and count cycles until DONE.
    task automatic run(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, output int lat,
                       output bit busy_ok);
        @(posedge CLK); #1;
        START = 1'b1; OP = op; IN0 = a; IN1 = b;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 0;
        busy_ok = BUSY;
        while (1) begin
            IN0 = 8'($urandom);
            IN1 = 8'($urandom);
            OP  = 4'($urandom);
            @(posedge CLK); #1;
            lat++;
            if (!BUSY) busy_ok = 1'b0;
            if (DONE || lat > 40) break;
        end
    endtask

    initial begin
        int lat;
        bit busy_ok;
        int dones;

        vecs.push_back(mk(4'b0101, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 1));
        vecs.push_back(mk(4'b0100, 8'h03, 8'h05, 8'hFE, 0, 1, 1, 1));
        vecs.push_back(mk(4'b1011, 8'h12, 8'h00, 8'h00, 0, 1, 1, 1));
        vecs.push_back(mk(4'b1101, 8'h81, 8'h03, 8'h08, 0, 0, 0, 4));
        vecs.push_back(mk(4'b1101, 8'h81, 8'h00, 8'h81, 0, 0, 1, 1));
        vecs.push_back(mk(4'b1111, 8'h10, 8'h11, 8'h10, 0, 1, 0, 9));
        vecs.push_back(mk(4'b1111, 8'h0F, 8'h03, 8'h2D, 0, 0, 0, 9));
        vecs.push_back(mk(4'b0000, 8'hA5, 8'h00, 8'h5A, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0001, 8'h3C, 8'hC3, 8'hFF, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0010, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1));
        vecs.push_back(mk(4'b0011, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0110, 8'h03, 8'h00, 8'h01, 0, 1, 0, 1));
        vecs.push_back(mk(4'b0111, 8'h80, 8'h00, 8'h00, 1, 1, 0, 1));
        vecs.push_back(mk(4'b1000, 8'h00, 8'h00, 8'hFF, 0, 1, 1, 1));
        vecs.push_back(mk(4'b1001, 8'hFF, 8'h00, 8'h00, 1, 1, 0, 1));
        vecs.push_back(mk(4'b1010, 8'h77, 8'h00, 8'h77, 1, 1, 0, 1));
        vecs.push_back(mk(4'b1100, 8'h0F, 8'hF0, 8'h00, 1, 0, 0, 1));
        vecs.push_back(mk(4'b1110, 8'hF1, 8'h0C, 8'h0F, 0, 0, 0, 5));
        vecs.push_back(mk(4'b1110, 8'h8C, 8'h03, 8'h11, 0, 1, 0, 4));
        vecs.push_back(mk(4'b1111, 8'hFF, 8'hFF, 8'h01, 0, 1, 0, 9));
        vecs.push_back(mk(4'b0100, 8'h05, 8'h05, 8'h00, 1, 0, 0, 1));
        vecs.push_back(mk(4'b1101, 8'h01, 8'h07, 8'h80, 0, 0, 1, 8));
        vecs.push_back(mk(4'b1001, 8'h7F, 8'h00, 8'h80, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0101, 8'h80, 8'h80, 8'h00, 1, 1, 0, 1));

        RST = 1'b1; START = 1'b0; IN0 = '0; IN1 = '0; OP = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_out", OUT, 0);
        chk("rst_flags", {ZF, CF, NF}, 0);

        foreach (vecs[i]) begin
            run(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_ok);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy", i), busy_ok, 1);
            chk($sformatf("v%0d_out", i), OUT, vecs[i].out);
            chk($sformatf("v%0d_zcn", i), {ZF, CF, NF},
                {vecs[i].z, vecs[i].c, vecs[i].n});
        end

        // START held through the DONE cycle must wait for the next IDLE
        START = 1'b1; OP = 4'b1011; IN0 = 8'h00; IN1 = 8'h55;
        @(posedge CLK); #1;
        chk("sdone_busy", BUSY, 0);
        chk("sdone_done", DONE, 0);
        @(posedge CLK); #1;
        START = 1'b0;
        chk("sdone_accept", BUSY, 1);
        @(posedge CLK); #1;
        chk("sdone_pulse", DONE, 1);
        chk("sdone_out", OUT, 8'h55);

        // Multiply disturbed by a busy START, then aborted by reset
        @(posedge CLK); #1;
        START = 1'b1; OP = 4'b1111; IN0 = 8'h10; IN1 = 8'h11;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        START = 1'b1; OP = 4'b1011; IN0 = 8'hFF; IN1 = 8'hFF;
        @(posedge CLK); #1;
        START = 1'b0;
        chk("abort_busy", BUSY, 1);
        chk("abort_nodone", DONE, 0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        START = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        START = 1'b0;
        chk("abort_idle", BUSY, 0);
        chk("abort_out", OUT, 0);
        chk("abort_flags", {ZF, CF, NF}, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) dones++;
        end
        chk("abort_quiet", dones, 0);

        run(4'b1111, 8'h0F, 8'h03, lat, busy_ok);
        chk("fresh_lat", lat, 9);
        chk("fresh_out", OUT, 8'h2D);
        chk("fresh_zcn", {ZF, CF, NF}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
